// File: rtl/bus_arbiter_mux_if.sv
// Bus source request/data bundle and registered bus result of bus_arbiter_mux.
// master: request side (control unit); slave: the arbiter itself.
interface bus_arbiter_mux_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 24,
    parameter int SELW  = 5,
    parameter int CNTW  = 16
) ();
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_req;
    logic                  lock;
    logic                  cnt_clr;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [SELW-1:0]       bus_sel;
    logic [NSRC-1:0]       grant;
    logic                  conflict;
    logic [CNTW-1:0]       conflict_cnt;

    modport master (
        output src_data, src_req, lock, cnt_clr,
        input  bus_out, bus_valid, bus_sel,
        input  grant, conflict, conflict_cnt
    );

    modport slave (
        input  src_data, src_req, lock, cnt_clr,
        output bus_out, bus_valid, bus_sel,
        output grant, conflict, conflict_cnt
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered bus source arbiter/mux with grant locking and conflict counting.
// Define BUS_ARB_RR_EN for round-robin arbitration (default: lowest index wins).
module bus_arbiter_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 24,
    parameter int SELW  = 5,
    parameter int CNTW  = 16
) (
    input logic              clk,
    input logic              clr,
    bus_arbiter_mux_if.slave bus
);
    logic [NSRC-1:0]  req;
    logic [NSRC-1:0]  grant_q, grant_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic             conf_q, conf_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [SELW-1:0]  win;
    logic             hold;
    logic             arb;
    logic             multi;

    assign req   = bus.src_req;
    assign hold  = valid_q & bus.lock & req[sel_q];
    assign arb   = ~hold & (|req);
    // more than one bit set <=> clearing the lowest set bit leaves something
    assign multi = |(req & (req - NSRC'(1)));

`ifdef BUS_ARB_RR_EN
    logic [SELW-1:0] ptr_q, ptr_d;

    // search starts just after the last winner and wraps at NSRC-1
    always_comb begin
        int   idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!found && req[idx]) begin
                win   = SELW'(idx);
                found = 1'b1;
            end
        end
    end

    assign ptr_d = arb ? win : ptr_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) ptr_q <= SELW'(NSRC - 1);
        else      ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (req[i]) win = SELW'(i);
    end
`endif

    always_comb begin
        grant_d = grant_q;
        sel_d   = sel_q;
        bus_d   = bus_q;
        valid_d = valid_q;
        conf_d  = 1'b0;
        unique case (1'b1)
            hold: begin
                bus_d = bus.src_data[int'(sel_q)*WIDTH +: WIDTH];
            end
            arb: begin
                grant_d      = '0;
                grant_d[win] = 1'b1;
                sel_d        = win;
                bus_d        = bus.src_data[int'(win)*WIDTH +: WIDTH];
                valid_d      = 1'b1;
                conf_d       = multi;
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
        if (bus.cnt_clr)
            cnt_d = '0;
        else if (conf_d && cnt_q != '1)
            cnt_d = cnt_q + CNTW'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            grant_q <= '0;
            sel_q   <= '0;
            bus_q   <= '0;
            valid_q <= 1'b0;
            conf_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_d;
            sel_q   <= sel_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            conf_q  <= conf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.bus_out      = bus_q;
    assign bus.bus_valid    = valid_q;
    assign bus.bus_sel      = sel_q;
    assign bus.grant        = grant_q;
    assign bus.conflict     = conf_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench for bus_arbiter_mux (fixed and BUS_ARB_RR_EN builds).
// Second instance with CNTW=2 covers counter saturation.
module tb_bus_arbiter_mux;
    localparam int W = 32;
    localparam int N = 24;
    localparam int S = 5;
`ifdef BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] bus;
        logic        valid;
        logic [4:0]  sel;
        logic [23:0] grant;
        logic        conf;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .SELW(S), .CNTW(16)) a ();
    bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .SELW(S), .CNTW(2))  b ();

    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .SELW(S), .CNTW(16)) dut (
        .clk(clk), .clr(clr), .bus(a)
    );
    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .SELW(S), .CNTW(2)) dut_sat (
        .clk(clk), .clr(clr), .bus(b)
    );

    int          checks   = 0;
    int          failures = 0;
    exp_t        sbq[$];
    logic [15:0] ecnt = '0;
    logic [31:0] dat [N];

    function automatic logic [23:0] oh(int i);
        return 24'd1 << i;
    endfunction

    task automatic set_data(int i, logic [31:0] v);
        dat[i] = v;
        a.src_data[i*W +: W] = v;
        b.src_data[i*W +: W] = v;
    endtask

    function automatic exp_t mk(int sel, logic valid, logic conf,
                                logic [15:0] cnt);
        exp_t e;
        e.bus   = dat[sel];
        e.valid = valid;
        e.sel   = 5'(sel);
        e.grant = valid ? oh(sel) : 24'd0;
        e.conf  = conf;
        e.cnt   = cnt;
        return e;
    endfunction

    function automatic exp_t obs_a();
        return {a.bus_out, a.bus_valid, a.bus_sel,
                a.grant, a.conflict, a.conflict_cnt};
    endfunction

    function automatic exp_t obs_b();
        return {b.bus_out, b.bus_valid, b.bus_sel,
                b.grant, b.conflict, 14'd0, b.conflict_cnt};
    endfunction

    task automatic test_reset();
        exp_t e, o;
        #12;
        sbq.push_back(exp_t'(0));
        e = sbq.pop_front(); o = obs_a(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_init: got %h want %h", o, e);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        sbq.push_back(exp_t'(0));
        @(posedge clk); #1;
        e = sbq.pop_front(); o = obs_a(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_idle: got %h want %h", o, e);
        end
        a.src_req = oh(21);
        a.lock    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(mk(21, 1'b1, 1'b0, 16'd0));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = obs_a(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_pre[%0d]: got %h want %h", i, o, e);
            end
        end
        #3;
        clr = 1'b0;
        sbq.push_back(exp_t'(0));
        #1;
        e = sbq.pop_front(); o = obs_a(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_async: got %h want %h", o, e);
        end
        a.src_req = '0;
        a.lock    = 1'b0;
        @(posedge clk); #1;
        clr  = 1'b1;
        ecnt = '0;
    endtask

    task automatic test_single();
        exp_t e, o;
        set_data(21, 32'hDEADBEEF);
        a.src_req = oh(21);
        sbq.push_back(mk(21, 1'b1, 1'b0, ecnt));
        @(posedge clk); #1;
        e = sbq.pop_front(); o = obs_a(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL single: got %h want %h", o, e);
        end
        a.src_req = '0;
        sbq.push_back(mk(21, 1'b0, 1'b0, ecnt));
        @(posedge clk); #1;
        e = sbq.pop_front(); o = obs_a(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL single_idle: got %h want %h", o, e);
        end
    endtask

    task automatic test_conflict();
        int   fx[4] = '{3, 3, 3, 3};
        int   rr[4] = '{3, 20, 3, 3};
        exp_t e, o;
        for (int i = 0; i < 4; i++) begin
            a.src_req = (i < 3) ? (oh(3) | oh(20)) : 24'd0;
            if (i < 3) ecnt++;
            sbq.push_back(mk(RR ? rr[i] : fx[i], i < 3, i < 3, ecnt));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = obs_a(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL conflict[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_lock();
        logic [23:0] rq[7] = '{oh(20), oh(20) | oh(0), oh(20) | oh(0),
                               oh(0), 24'd0, oh(0) | oh(5), 24'd0};
        bit   lk[7] = '{0, 1, 1, 1, 0, 1, 0};
        int   fx[7] = '{20, 20, 20, 0, 0, 0, 0};
        int   rr[7] = '{20, 20, 20, 0, 0, 5, 5};
        bit   vl[7] = '{1, 1, 1, 1, 0, 1, 0};
        bit   cf[7] = '{0, 0, 0, 0, 0, 1, 0};
        exp_t e, o;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) set_data(20, 32'd5);
            if (i == 2) set_data(20, 32'd6);
            a.src_req = rq[i];
            a.lock    = lk[i];
            if (cf[i]) ecnt++;
            sbq.push_back(mk(RR ? rr[i] : fx[i], vl[i], cf[i], ecnt));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = obs_a(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lock[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_cnt_clr();
        int   fx[3] = '{1, 1, 1};
        int   rr[3] = '{1, 2, 2};
        exp_t e, o;
        for (int i = 0; i < 3; i++) begin
            a.src_req = (i < 2) ? (oh(1) | oh(2)) : 24'd0;
            a.cnt_clr = (i == 0);
            if (i == 0) ecnt = '0;
            if (i == 1) ecnt++;
            sbq.push_back(mk(RR ? rr[i] : fx[i], i < 2, i < 2, ecnt));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = obs_a(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL cnt_clr[%0d]: got %h want %h", i, o, e);
            end
        end
        a.cnt_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   rr[5] = '{0, 5, 23, 0, 5};
        exp_t e, o;
        #2 clr = 1'b0;
        #2 clr = 1'b1;
        ecnt = '0;
        @(posedge clk); #1;
        a.src_req = oh(0) | oh(5) | oh(23);
        for (int i = 0; i < 5; i++) begin
            ecnt++;
            sbq.push_back(mk(RR ? rr[i] : 0, 1'b1, 1'b1, ecnt));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = obs_a(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b[%0d]: got %h want %h", i, o, e);
            end
        end
        a.src_req = '0;
    endtask

    task automatic test_saturation();
        int          rr[6] = '{3, 20, 3, 20, 3, 20};
        logic [15:0] sc[6] = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd0};
        exp_t        e, o;
        b.src_req = oh(3) | oh(20);
        for (int i = 0; i < 6; i++) begin
            b.cnt_clr = (i == 5);
            sbq.push_back(mk(RR ? rr[i] : 3, 1'b1, 1'b1, sc[i]));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = obs_b(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sat[%0d]: got %h want %h", i, o, e);
            end
        end
        b.src_req = '0;
        b.cnt_clr = 1'b0;
    endtask

    initial begin
        a.src_req = '0; a.lock = 1'b0; a.cnt_clr = 1'b0;
        b.src_req = '0; b.lock = 1'b0; b.cnt_clr = 1'b0;
        for (int i = 0; i < N; i++)
            set_data(i, 32'h1000_0000 + 32'(i));
        test_reset();
        test_single();
        test_conflict();
        test_lock();
        test_cnt_clr();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
